// File: rtl/chip_tx_pkg.sv
// Shared types and constants for the chip input streamer.
//   tx_state_e   : top-level sequencing states (IDLE, RUN, DONE)
//   STALL_CNT_W  : width of the optional per-lane stall counters
//   clog2_min1() : address width helper that never returns 0
package chip_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tx_state_e;

  localparam int STALL_CNT_W = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chip_input_streamer_if.sv
// Bus bundle between the streamer, its two host source buffers and the chip.
//   a_src_* / b_src_* : read port into the activation / weight source buffers
//                       (data returns one cycle after the address is issued)
//   a_* / b_*         : valid/ready streams into the chip's a_input / b_input
// master = streamer side, slave = source buffers + chip side.
interface chip_tx_if #(
  parameter int DATA_W = 16,
  parameter int A_AW   = 1,
  parameter int B_AW   = 1
);
  logic [A_AW-1:0]   a_src_addr;
  logic              a_src_en;
  logic [DATA_W-1:0] a_src_data;
  logic [B_AW-1:0]   b_src_addr;
  logic              b_src_en;
  logic [DATA_W-1:0] b_src_data;

  logic [DATA_W-1:0] a_input;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] b_input;
  logic              b_valid;
  logic              b_ready;

  modport master (
    output a_src_addr, a_src_en, input a_src_data,
    output b_src_addr, b_src_en, input b_src_data,
    output a_input, a_valid, input a_ready,
    output b_input, b_valid, input b_ready
  );

  modport slave (
    input a_src_addr, a_src_en, output a_src_data,
    input b_src_addr, b_src_en, output b_src_data,
    input a_input, a_valid, output a_ready,
    input b_input, b_valid, output b_ready
  );
endinterface

// File: rtl/tx_stream_lane.sv
// One transmit lane: walks source addresses 0..COUNT-1, buffers returned words
// in a 2-entry FIFO and presents the FIFO head on a valid/ready stream.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   clr_i           : restart lane (accepted start)
//   run_i           : lane may issue reads
//   src_addr_o/en_o : source read request; src_data_i returns next cycle
//   data_o/valid_o  : stream word and valid, ready_i accepts it
//   fin_next_o      : all COUNT words will have been transferred after this cycle
module tx_stream_lane
  import chip_tx_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int COUNT  = 32,
  localparam int AW     = clog2_min1(COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              run_i,
  output logic [AW-1:0]     src_addr_o,
  output logic              src_en_o,
  input  logic [DATA_W-1:0] src_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              fin_next_o
);

  localparam int            CW   = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT);

  logic [CW-1:0]            addr_q, addr_d;
  logic [CW-1:0]            xfer_q, xfer_d;
  logic                     inflight_q, inflight_d;
  logic [1:0]               cnt_q, cnt_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0][DATA_W-1:0]   mem_q, mem_d;
  logic                     pop, issue;
  logic [1:0]               occ;

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign pop     = valid_o & ready_i;

  // Slots committed once this cycle's pop retires; the in-flight word already
  // owns one. Crediting the pop keeps 1 word/cycle with ready held high.
  assign occ   = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue = run_i & ~clr_i & (addr_q < LAST) & (occ < 2'd2);

  assign src_en_o   = issue;
  assign src_addr_o = addr_q[AW-1:0];
  assign fin_next_o = (xfer_d == LAST);

  always_comb begin
    addr_d     = addr_q;
    xfer_d     = xfer_q;
    inflight_d = 1'b0;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    if (clr_i) begin
      addr_d   = '0;
      xfer_d   = '0;
      cnt_d    = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) addr_d = addr_q + 1'b1;
      if (inflight_q) begin
        mem_d[wr_ptr_q] = src_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        xfer_d   = xfer_q + 1'b1;
      end
      cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      xfer_q     <= xfer_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: rtl/chip_input_streamer.sv
// Host-side transmitter for the chip's a/b input streams. On start, both lanes
// read their source buffers in linear order and push the words into the chip.
// Ports:
//   clk, arst_n_in : clock, async active-low reset
//   start          : 1-cycle start pulse (ignored unless idle)
//   busy           : streaming in progress
//   done           : 1-cycle pulse after the last word of both lanes is taken
//   tx             : chip_tx_if master (source read ports + chip streams)
//   a/b_stall_cnt  : RUN cycles with valid && !ready, saturating
//                    (only when CHIP_TX_STALL_CNT_EN is defined)
module chip_input_streamer
  import chip_tx_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int KERNEL_SIZE        = 3
) (
  input  logic clk,
  input  logic arst_n_in,
  input  logic start,
  output logic busy,
  output logic done,
  chip_tx_if.master tx
`ifdef CHIP_TX_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] a_stall_cnt,
  output logic [STALL_CNT_W-1:0] b_stall_cnt
`endif
);

  localparam int A_COUNT = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * INPUT_NB_CHANNELS;
  localparam int B_COUNT = OUTPUT_NB_CHANNELS * KERNEL_SIZE * KERNEL_SIZE * INPUT_NB_CHANNELS;

  tx_state_e state_q, state_d;
  logic      accept, run;
  logic      a_fin_next, b_fin_next;

  assign accept = (state_q == IDLE) & start;
  assign run    = (state_q == RUN);
  assign busy   = run;
  assign done   = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      // Finish off the *next* transfer count so done lands one cycle after
      // the later lane's last transfer.
      RUN:     if (a_fin_next && b_fin_next) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  tx_stream_lane #(.DATA_W(IO_DATA_WIDTH), .COUNT(A_COUNT)) u_lane_a (
    .clk        (clk),
    .rst_n      (arst_n_in),
    .clr_i      (accept),
    .run_i      (run),
    .src_addr_o (tx.a_src_addr),
    .src_en_o   (tx.a_src_en),
    .src_data_i (tx.a_src_data),
    .data_o     (tx.a_input),
    .valid_o    (tx.a_valid),
    .ready_i    (tx.a_ready),
    .fin_next_o (a_fin_next)
  );

  tx_stream_lane #(.DATA_W(IO_DATA_WIDTH), .COUNT(B_COUNT)) u_lane_b (
    .clk        (clk),
    .rst_n      (arst_n_in),
    .clr_i      (accept),
    .run_i      (run),
    .src_addr_o (tx.b_src_addr),
    .src_en_o   (tx.b_src_en),
    .src_data_i (tx.b_src_data),
    .data_o     (tx.b_input),
    .valid_o    (tx.b_valid),
    .ready_i    (tx.b_ready),
    .fin_next_o (b_fin_next)
  );

`ifdef CHIP_TX_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] a_stall_q, a_stall_d, b_stall_q, b_stall_d;

  always_comb begin
    a_stall_d = a_stall_q;
    b_stall_d = b_stall_q;
    if (accept) begin
      a_stall_d = '0;
      b_stall_d = '0;
    end else if (run) begin
      if (tx.a_valid && !tx.a_ready && (a_stall_q != '1)) a_stall_d = a_stall_q + 1'b1;
      if (tx.b_valid && !tx.b_ready && (b_stall_q != '1)) b_stall_d = b_stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      a_stall_q <= '0;
      b_stall_q <= '0;
    end else begin
      a_stall_q <= a_stall_d;
      b_stall_q <= b_stall_d;
    end
  end

  assign a_stall_cnt = a_stall_q;
  assign b_stall_cnt = b_stall_q;
`endif

endmodule
